ov7670_power_seq: RTL and testbench

OV7670_POWER_SEQ -- requirements
Module: ov7670_power_seq

---
 rtl/ov7670_pkg.sv | 55 +++++
 rtl/sync_bit.sv | 22 ++
 rtl/ov7670_power_seq.sv | 110 +++++++++++
 tb/tb_ov7670_power_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 power sequencer: state encodings, debug width
// and the per-state pin decode used to register the outputs.
package ov7670_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] ST_LOCK_WAIT = 3'd1;
    localparam logic [STATE_W-1:0] ST_PWR_UP    = 3'd2;
    localparam logic [STATE_W-1:0] ST_SETTLE    = 3'd3;
    localparam logic [STATE_W-1:0] ST_START     = 3'd4;
    localparam logic [STATE_W-1:0] ST_RUN       = 3'd5;

    typedef struct packed {
        logic cam_pwdn;
        logic cam_reset_n;
        logic sys_rst;
        logic cfg_start;
        logic ready;
    } pins_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Camera held powered-down and in reset, downstream in reset, unless told otherwise.
    function automatic pins_t decode_pins(input logic [STATE_W-1:0] st);
        pins_t p;
        p = '{cam_pwdn: 1'b1, cam_reset_n: 1'b0, sys_rst: 1'b1, cfg_start: 1'b0, ready: 1'b0};
        case (st)
            ST_PWR_UP: p.cam_pwdn = 1'b0;
            ST_SETTLE: begin
                p.cam_pwdn    = 1'b0;
                p.cam_reset_n = 1'b1;
            end
            ST_START: begin
                p.cam_pwdn    = 1'b0;
                p.cam_reset_n = 1'b1;
                p.sys_rst     = 1'b0;
                p.cfg_start   = 1'b1;
            end
            ST_RUN: begin
                p.cam_pwdn    = 1'b0;
                p.cam_reset_n = 1'b1;
                p.sys_rst     = 1'b0;
                p.ready       = 1'b1;
            end
            default: ;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level signal.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: reset is synchronous; it only takes effect on a clock edge.
    always_ff @(posedge clk) begin
        if (rst) ff <= '0;
        else     ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/ov7670_power_seq.sv
// OV7670 power-up sequencer: waits for a stable PLL lock, pulses the camera reset,
// lets it settle, then kicks off the SCCB loader and releases downstream reset.
module ov7670_power_seq
    import ov7670_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_CYCLES       = 50000,
    parameter int SETTLE_CYCLES      = 50000,
    parameter int SYNC_STAGES        = 2
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               locked,
    input  logic               restart,
    output logic               cam_pwdn,
    output logic               cam_reset_n,
    output logic               sys_rst,
    output logic               cfg_start,
    output logic               ready,
    output logic [STATE_W-1:0] state_o
);

    localparam int CNT_MAX = max3(LOCK_STABLE_CYCLES, RESET_CYCLES, SETTLE_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic               lock_s;
    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    pins_t              pins_q;

    sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (locked),
        .q   (lock_s)
    );

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (lock_s) begin
                state_d = ST_LOCK_WAIT;
                cnt_d   = '0;
            end
            ST_LOCK_WAIT: if (cnt_q == LOCK_LAST) begin
                state_d = ST_PWR_UP;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            ST_PWR_UP: if (cnt_q == RESET_LAST) begin
                state_d = ST_SETTLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            ST_SETTLE: if (cnt_q == SETTLE_LAST) begin
                state_d = ST_START;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            ST_START: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
            ST_RUN: if (restart) begin
                state_d = ST_PWR_UP;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Losing lock anywhere in the sequence wins over restart and counter expiry.
        if (state_q != ST_IDLE && !lock_s) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    // Outputs are loaded from the next-state decode so they line up with state_q.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pins_q  <= decode_pins(ST_IDLE);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pins_q  <= decode_pins(state_d);
        end
    end

    assign cam_pwdn    = pins_q.cam_pwdn;
    assign cam_reset_n = pins_q.cam_reset_n;
    assign sys_rst     = pins_q.sys_rst;
    assign cfg_start   = pins_q.cfg_start;
    assign ready       = pins_q.ready;
    assign state_o     = state_q;

endmodule

// File: tb/tb_ov7670_power_seq.sv
// Bench for ov7670_power_seq: directed vector table, corner-case sequences and a
// randomized run against an elapsed-time reference model.
module tb_ov7670_power_seq;

    localparam int L  = 8;
    localparam int R  = 20;
    localparam int S  = 30;
    localparam int SS = 2;

    // {state_o, cam_pwdn, cam_reset_n, sys_rst, cfg_start, ready}
    localparam logic [7:0] O_IDLE   = {3'd0, 5'b10100};
    localparam logic [7:0] O_LWAIT  = {3'd1, 5'b10100};
    localparam logic [7:0] O_PWR    = {3'd2, 5'b00100};
    localparam logic [7:0] O_SETTLE = {3'd3, 5'b01100};
    localparam logic [7:0] O_START  = {3'd4, 5'b01010};
    localparam logic [7:0] O_RUN    = {3'd5, 5'b01001};

    logic       refclk = 1'b0;
    logic       rst = 1'b1, locked = 1'b0, restart = 1'b0;
    logic       cam_pwdn, cam_reset_n, sys_rst, cfg_start, ready;
    logic [2:0] state_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cfg_pulses = 0;

    // Reference model: -2 idle, -1 lock wait, t>=0 cycles since PWR_UP entry.
    int          m_t  = -2;
    int          m_lw = 0;
    logic [SS-1:0] m_hist = '0;

    ov7670_power_seq #(
        .LOCK_STABLE_CYCLES (L),
        .RESET_CYCLES       (R),
        .SETTLE_CYCLES      (S),
        .SYNC_STAGES        (SS)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .locked      (locked),
        .restart     (restart),
        .cam_pwdn    (cam_pwdn),
        .cam_reset_n (cam_reset_n),
        .sys_rst     (sys_rst),
        .cfg_start   (cfg_start),
        .ready       (ready),
        .state_o     (state_o)
    );

    always #5 refclk = ~refclk;

    always @(negedge refclk) if (cfg_start === 1'b1) cfg_pulses++;

    function automatic logic [7:0] got();
        return {state_o, cam_pwdn, cam_reset_n, sys_rst, cfg_start, ready};
    endfunction

    function automatic logic [7:0] model_exp();
        if (m_t == -2)         return O_IDLE;
        if (m_t == -1)         return O_LWAIT;
        if (m_t < R)           return O_PWR;
        if (m_t < R + S)       return O_SETTLE;
        if (m_t == R + S)      return O_START;
        return O_RUN;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_step();
        logic ls;
        ls = m_hist[SS-1];
        if (rst) begin
            m_t    = -2;
            m_lw   = 0;
            m_hist = '0;
        end else begin
            if (m_t == -2) begin
                if (ls) begin m_t = -1; m_lw = 0; end
            end else if (!ls) begin
                m_t = -2;
            end else if (m_t == -1) begin
                if (m_lw == L - 1) m_t = 0;
                else               m_lw++;
            end else if (m_t > R + S) begin
                if (restart) m_t = 0;
            end else begin
                m_t++;
            end
            m_hist = {m_hist[SS-2:0], locked};
        end
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge refclk);
        #1;
        check(tag, 32'(got()), 32'(model_exp()));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick("model");
    endtask

    typedef struct {
        logic       rst;
        logic       locked;
        logic       restart;
        int         cycles;
        logic [7:0] exp_out;
    } vec_t;

    vec_t vecs[20];
    int   cfg_snap;

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 2,  O_IDLE};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 2,  O_IDLE};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1,  O_LWAIT};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 7,  O_LWAIT};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1,  O_PWR};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 19, O_PWR};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1,  O_SETTLE};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 29, O_SETTLE};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1,  O_START};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1,  O_RUN};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 5,  O_RUN};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1,  O_PWR};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 50, O_START};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1,  O_RUN};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 2,  O_RUN};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1,  O_IDLE};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 3,  O_LWAIT};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 8,  O_PWR};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 5,  O_PWR};
        vecs[19] = '{1'b1, 1'b1, 1'b0, 1,  O_IDLE};

        #1;
        for (int v = 0; v < 20; v++) begin
            rst     = vecs[v].rst;
            locked  = vecs[v].locked;
            restart = vecs[v].restart;
            run(vecs[v].cycles);
            check($sformatf("vec%0d", v), 32'(got()), 32'(vecs[v].exp_out));
        end
        check("cfg_pulses_two_runs", 32'(cfg_pulses), 32'd2);

        // One-cycle lock glitch in LOCK_WAIT: back to IDLE, full stability count again.
        rst = 1'b0; restart = 1'b0; locked = 1'b1;
        run(3);
        check("glitch_enter_lw", 32'(got()), 32'(O_LWAIT));
        run(3);
        locked = 1'b0; run(1);
        locked = 1'b1; run(1);
        check("glitch_still_lw", 32'(got()), 32'(O_LWAIT));
        run(1);
        check("glitch_idle", 32'(got()), 32'(O_IDLE));
        run(1);
        check("glitch_relock", 32'(got()), 32'(O_LWAIT));
        run(7);
        check("glitch_full_count", 32'(got()), 32'(O_LWAIT));
        run(1);
        check("glitch_pwr_up", 32'(got()), 32'(O_PWR));

        // Lock loss at SETTLE cycle 10: IDLE after sync latency + 1, no cfg_start.
        run(20);
        check("settle_enter", 32'(got()), 32'(O_SETTLE));
        run(10);
        cfg_snap = cfg_pulses;
        locked = 1'b0;
        run(2);
        check("settle_latency", 32'(got()), 32'(O_SETTLE));
        run(1);
        check("settle_drop_idle", 32'(got()), 32'(O_IDLE));
        run(60);
        check("settle_no_cfg", 32'(cfg_pulses), 32'(cfg_snap));

        // Randomized run against the reference model.
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 999) == 0);
            locked  = ($urandom_range(0, 63) != 0);
            restart = ($urandom_range(0, 49) == 0);
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
